addsub_seq: RTL and testbench

- Command-driven operand sequencer and accumulator sitting directly upstream of the 4-bit ripple adder/subtractor.
- Accepts LOAD/ADD/SUB/CLEAR commands over a valid/ready handshake and registers the operands onto the adder's x/y/cin inputs.
- Captures the adder's sum/cout back into an accumulator with status flags, then returns each result over a response handshake.
- The adder stays purely combinational and is instantiated alongside this block; its inversion of y by cin is the only subtract mechanism.

---
 rtl/addsub_seq.sv | 190 +++++++++++++++++++
 tb/tb_addsub_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
//
// Command-driven operand sequencer and accumulator for an external, purely
// combinational 4-bit ripple adder/subtractor. LOAD/ADD/SUB/CLEAR commands
// arrive over a valid/ready handshake. ADD/SUB operands are registered onto
// the adder's x/y/cin inputs, and the adder result is captured one cycle
// later. Each completed command returns the accumulator over a response
// handshake.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_op: 00 LOAD, 01 ADD,
//                         10 SUB, 11 CLEAR; cmd_data: operand)
//   as_x/as_y/as_cin      registered operands driven to the adder
//                         (as_y is raw; the adder inverts it when cin=1)
//   as_sum/as_cout        adder result
//   rsp_valid/rsp_ready   response handshake, rsp_data = accumulator
//   carry_flag, ovf_flag  cout / signed overflow of the last ADD/SUB
//   zero_flag             accumulator == 0
//   op_count              saturating count of completed ADD/SUB commands
// -----------------------------------------------------------------------------
module addsub_seq #(
    parameter int WIDTH   = 4,
    parameter int OPCNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic [WIDTH-1:0]   as_x,
    output logic [WIDTH-1:0]   as_y,
    output logic               as_cin,
    input  logic [WIDTH-1:0]   as_sum,
    input  logic               as_cout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               carry_flag,
    output logic               ovf_flag,
    output logic               zero_flag,
    output logic [OPCNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 cin_q, cin_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic [OPCNT_W-1:0]   cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH-1:0]     y_eff;
    logic                 sum_ovf;

    assign accept  = (state_q == S_IDLE) && cmd_valid;

    // The adder sees y inverted when cin=1, so overflow must be judged
    // against the effective operand, not the raw one we drive.
    assign y_eff   = y_q ^ {WIDTH{cin_q}};
    assign sum_ovf = (x_q[WIDTH-1] == y_eff[WIDTH-1]) &&
                     (as_sum[WIDTH-1] != x_q[WIDTH-1]);

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every signal written in a combinational block gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_op == OP_ADD || cmd_op == OP_SUB) ? S_EXEC : S_RESP;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    // ---------------------------------------------------------------- datapath next
    always_comb begin
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        if (accept) begin
            case (cmd_op)
                OP_LOAD: begin
                    acc_d   = cmd_data;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = (cmd_data == '0);
                end
                OP_CLEAR: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    zero_d  = 1'b1;
                end
                default: begin
                    // ADD/SUB: x takes the current accumulator, the adder
                    // result is captured in EXEC.
                    x_d   = acc_q;
                    y_d   = cmd_data;
                    cin_d = (cmd_op == OP_SUB);
                end
            endcase
        end else if (state_q == S_EXEC) begin
            acc_d   = as_sum;
            carry_d = as_cout;
            zero_d  = (as_sum == '0);
            ovf_d   = sum_ovf;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + OPCNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign as_x       = x_q;
    assign as_y       = y_q;
    assign as_cin     = cin_q;
    assign rsp_data   = acc_q;
    assign carry_flag = carry_q;
    assign ovf_flag   = ovf_q;
    assign zero_flag  = zero_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq
//
// Directed bench for addsub_seq. A stand-in for the combinational adder
// closes the loop. A plain-integer reference model predicts every response
// from the command sequence. A negedge compare process checks each response
// against that model, and directed checks pin latency, operand registers,
// backpressure, reset behaviour and counter saturation to literal values.
// -----------------------------------------------------------------------------
module tb_addsub_seq;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] as_x, as_y, as_sum;
    logic       as_cin, as_cout;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       carry_flag, ovf_flag, zero_flag;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    // Combinational 4-bit adder/subtractor the block drives.
    logic [4:0] add_full;
    assign add_full = {1'b0, as_x} + {1'b0, as_y ^ {4{as_cin}}} + {4'b0, as_cin};
    assign as_sum   = add_full[3:0];
    assign as_cout  = add_full[4];

    addsub_seq #(.WIDTH(4), .OPCNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .as_x       (as_x),
        .as_y       (as_y),
        .as_cin     (as_cin),
        .as_sum     (as_sum),
        .as_cout    (as_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .carry_flag (carry_flag),
        .ovf_flag   (ovf_flag),
        .zero_flag  (zero_flag),
        .op_count   (op_count)
    );

    // ---------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    typedef struct {
        int d;
        bit c;
        bit o;
        bit z;
        int cnt;
    } rsp_t;

    rsp_t exp_q[$];
    int   m_acc, m_cnt;
    bit   m_c, m_o;

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_c = 1'b0; m_o = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [3:0] dv);
        int d, sr;
        rsp_t r;
        d = int'(dv);
        case (op)
            LOAD:  begin m_acc = d; m_c = 1'b0; m_o = 1'b0; end
            CLEAR: begin m_acc = 0; m_c = 1'b0; m_o = 1'b0; m_cnt = 0; end
            ADD: begin
                sr    = to_signed4(m_acc) + to_signed4(d);
                m_c   = (m_acc + d) > 15;
                m_o   = (sr > 7) || (sr < -8);
                m_acc = (m_acc + d) % 16;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            default: begin // SUB
                sr    = to_signed4(m_acc) - to_signed4(d);
                m_c   = (m_acc >= d);
                m_o   = (sr > 7) || (sr < -8);
                m_acc = (m_acc - d + 16) % 16;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        endcase
        r.d = m_acc; r.c = m_c; r.o = m_o; r.z = (m_acc == 0); r.cnt = m_cnt;
        exp_q.push_back(r);
    endtask

    // Compare process: every cycle a response is presented, it must match the
    // oldest outstanding prediction; a handshake retires it.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_pending", exp_q.size(), 1);
            end else begin
                check("model_rsp_data", rsp_data,   exp_q[0].d);
                check("model_carry",    carry_flag, exp_q[0].c);
                check("model_ovf",      ovf_flag,   exp_q[0].o);
                check("model_zero",     zero_flag,  exp_q[0].z);
                check("model_op_count", op_count,   exp_q[0].cnt);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    int last_waits;

    // Presents a command, waits (bounded) until it is accepted, and returns
    // #1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [3:0] d);
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        last_waits = 0;
        do begin
            @(negedge clk);
            last_waits++;
        end while (!cmd_ready && last_waits < 20);
        check("cmd_accept_bound", cmd_ready, 1);
        model_cmd(op, d);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Called #1 after an accept edge: counts edges until rsp_valid, then
    // checks the response against literal values.
    task automatic expect_rsp(input string tag, input int lat, input int d,
                              input int c, input int o, input int z, input int cnt);
        int n;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_data"},  rsp_data,   d);
        check({tag, "_carry"}, carry_flag, c);
        check({tag, "_ovf"},   ovf_flag,   o);
        check({tag, "_zero"},  zero_flag,  z);
        check({tag, "_cnt"},   op_count,   cnt);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        cmd_valid = 1'b0; cmd_op = LOAD; cmd_data = 4'h0; rsp_ready = 1'b1;
        #1 reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_rsp_data",  rsp_data,   0);
        check("rst_zero",      zero_flag,  1);
        check("rst_carry",     carry_flag, 0);
        check("rst_ovf",       ovf_flag,   0);
        check("rst_op_count",  op_count,   0);
        check("rst_cmd_ready", cmd_ready,  1);
        check("rst_rsp_valid", rsp_valid,  0);
        check("rst_as_x",      as_x,       0);

        // LOAD 5, ADD 3 -> 8 with signed overflow
        send(LOAD, 4'd5);
        expect_rsp("load5", 0, 5, 0, 0, 0, 0);
        send(ADD, 4'd3);
        check("add3_exec_x",   as_x,      5);
        check("add3_exec_y",   as_y,      3);
        check("add3_exec_cin", as_cin,    0);
        check("add3_exec_rdy", cmd_ready, 0);
        expect_rsp("add3", 1, 8, 0, 1, 0, 1);

        // LOAD 3, SUB 3 -> 0 no borrow; LOAD 2, SUB 5 -> 0xD with borrow
        send(LOAD, 4'd3);
        expect_rsp("load3", 0, 3, 0, 0, 0, 1);
        send(SUB, 4'd3);
        check("sub3_exec_cin", as_cin, 1);
        check("sub3_exec_x",   as_x,   3);
        expect_rsp("sub3", 1, 0, 1, 0, 1, 2);
        send(LOAD, 4'd2);
        check("load_holds_x",   as_x,   3);
        check("load_holds_y",   as_y,   3);
        check("load_holds_cin", as_cin, 1);
        expect_rsp("load2", 0, 2, 0, 0, 0, 2);
        send(SUB, 4'd5);
        expect_rsp("sub5", 1, 13, 0, 0, 0, 3);

        // Wrap: 0xF + 1 -> 0 with carry, then CLEAR
        send(LOAD, 4'hF);
        expect_rsp("loadf", 0, 15, 0, 0, 0, 3);
        send(ADD, 4'd1);
        expect_rsp("wrap", 1, 0, 1, 0, 1, 4);
        send(CLEAR, 4'hA);
        expect_rsp("clear", 0, 0, 0, 0, 1, 0);

        // Backpressure: response held while a new command waits
        send(LOAD, 4'd6);
        expect_rsp("load6", 0, 6, 0, 0, 0, 0);
        send(ADD, 4'd2);
        rsp_ready = 1'b0;
        expect_rsp("bp_add", 1, 8, 0, 1, 0, 1);
        cmd_op = LOAD; cmd_data = 4'd9; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data",  rsp_data,  8);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        send(LOAD, 4'd9);
        check("bp_accept_waits", last_waits, 2);
        expect_rsp("bp_load9", 0, 9, 0, 0, 0, 1);

        // Asynchronous reset in the middle of an ADD's EXEC cycle
        send(ADD, 4'd3);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_rsp_valid", rsp_valid,  0);
        check("arst_rsp_data",  rsp_data,   0);
        check("arst_as_x",      as_x,       0);
        check("arst_as_y",      as_y,       0);
        check("arst_zero",      zero_flag,  1);
        check("arst_op_count",  op_count,   0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_no_rsp", rsp_valid, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst_released_no_rsp", rsp_valid, 0);
        send(LOAD, 4'd7);
        expect_rsp("post_rst_load7", 0, 7, 0, 0, 0, 0);

        // op_count saturates at 255 after 256 completed ADDs
        send(CLEAR, 4'd0);
        expect_rsp("sat_clear", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            send(ADD, 4'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("sat_op_count", op_count, 255);
        check("sat_acc",      rsp_data, 0);
        check("drained",      exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
